// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: FSM states, register offsets, CTRL fields.
// Optional prescaler is enabled by the TIMER_BANK_PRESCALE_EN macro.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IM     = 2;
    localparam int CTRL_PS_LSB = 4;
    localparam int CTRL_PS_MSB = 11;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_bank_if.sv
// Processor-side register bus of the timer bank; rdata is combinational from addr.
interface timer_bank_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              we;
    logic [31:0]       rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/timer_bank_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT/STATUS, FSM, sticky pending, registered irq.
// Prescaler present only when TIMER_BANK_PRESCALE_EN is defined.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);
    state_t             r_state;
    logic               r_en;
    logic               r_mode;
    logic               r_im;
    logic               r_pending;
    logic               r_irq;
    logic [WIDTH-1:0]   r_preset;
    logic [WIDTH-1:0]   r_count;
    logic               w_ctrl_we;
    logic               w_preset_we;
    logic               w_stat_we;
    logic               w_tick;
    logic               w_en_nxt;
    logic [7:0]         w_ps_rd;

    assign w_ctrl_we   = i_we && (i_off == OFF_CTRL);
    assign w_preset_we = i_we && (i_off == OFF_PRESET);
    assign w_stat_we   = i_we && (i_off == OFF_STATUS);

    // A CPU write to CTRL overrides the one-shot auto-clear of EN in the same cycle.
    assign w_en_nxt = w_ctrl_we ? i_wdata[CTRL_EN] :
                      ((r_state == S_INT) && (r_mode == MODE_ONESHOT)) ? 1'b0 : r_en;

`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0] r_ps;
    logic [7:0] r_psc;

    assign w_tick  = (r_psc == r_ps);
    assign w_ps_rd = r_ps;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps  <= '0;
            r_psc <= '0;
        end else begin
            if (w_ctrl_we) r_ps <= i_wdata[CTRL_PS_MSB:CTRL_PS_LSB];
            if (r_state == S_LOAD)     r_psc <= '0;
            else if (r_state == S_CNT) r_psc <= w_tick ? 8'd0 : r_psc + 8'd1;
        end
    end
`else
    assign w_tick  = 1'b1;
    assign w_ps_rd = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_en      <= 1'b0;
            r_mode    <= MODE_ONESHOT;
            r_im      <= 1'b0;
            r_pending <= 1'b0;
            r_irq     <= 1'b0;
            r_preset  <= '0;
            r_count   <= '0;
        end else begin
            r_en  <= w_en_nxt;
            r_irq <= r_pending & r_im;
            if (w_ctrl_we) begin
                r_mode <= i_wdata[CTRL_MODE];
                r_im   <= i_wdata[CTRL_IM];
            end
            if (w_preset_we) r_preset <= i_wdata[WIDTH-1:0];
            if (w_stat_we && i_wdata[0]) r_pending <= 1'b0;

            case (r_state)
                S_IDLE: if (w_en_nxt) r_state <= S_LOAD;
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: if (w_tick) begin
                    // PRESET of 0 expires on the first tick, same as PRESET of 1.
                    if (r_count > WIDTH'(1)) begin
                        r_count <= r_count - WIDTH'(1);
                    end else begin
                        r_count <= '0;
                        r_state <= S_INT;
                    end
                end
                default: begin
                    r_pending <= 1'b1;
                    r_state   <= (r_mode == MODE_RELOAD) ? S_LOAD : S_IDLE;
                end
            endcase

            // Clearing EN parks the FSM; COUNT keeps whatever this edge produced.
            if (!w_en_nxt) r_state <= S_IDLE;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_off)
            OFF_CTRL: begin
                o_rdata[CTRL_EN]                 = r_en;
                o_rdata[CTRL_MODE]               = r_mode;
                o_rdata[CTRL_IM]                 = r_im;
                o_rdata[CTRL_PS_MSB:CTRL_PS_LSB] = w_ps_rd;
            end
            OFF_PRESET: o_rdata = 32'(r_preset);
            OFF_COUNT:  o_rdata = 32'(r_count);
            default:    o_rdata[0] = r_pending;
        endcase
    end

    assign o_irq = r_irq;

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of NUM_CH timers: address decode, write fan-out, combinational read mux.
// Optional per-channel prescaler selected by the TIMER_BANK_PRESCALE_EN macro.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    timer_bank_if.slave       bus,
    output logic [NUM_CH-1:0] irq
);
    logic [ADDR_W-1:0] w_ch;
    logic [31:0]       w_rd [NUM_CH];

    assign w_ch = bus.addr >> 2;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic w_we;
            assign w_we = bus.we && (w_ch == ADDR_W'(i));

            timer_channel #(.WIDTH(WIDTH)) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_we),
                .i_off   (bus.addr[1:0]),
                .i_wdata (bus.wdata),
                .o_rdata (w_rd[i]),
                .o_irq   (irq[i])
            );
        end
    endgenerate

    // Unmapped channel slots fall through to zero.
    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == ADDR_W'(i)) bus.rdata = w_rd[i];
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (NUM_CH=2, WIDTH=32); honours TIMER_BANK_PRESCALE_EN.
module tb_timer_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] irq;
    int         errors = 0;
    int         checks = 0;
    logic [31:0] v;

    timer_bank_if #(.ADDR_W(5)) bus ();

    timer_bank #(.NUM_CH(2), .WIDTH(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic test_reset;
        logic [4:0] addrs [10];
        addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd31};
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        checks++;
        if (irq !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b want 00", irq); end
        foreach (addrs[i]) begin
            rd(addrs[i], v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL reset_reg[%0d]: got %h want 0", addrs[i], v); end
        end
        wr(5'd8, 32'hFFFF_FFFF);
        rd(5'd8, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL unmapped_write: got %h want 0", v); end
        rd(5'd0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL unmapped_alias: got %h want 0", v); end
    endtask

    task automatic test_oneshot;
        wr(5'd1, 32'd5);
        wr(5'd0, 32'h5);
        cyc(1); rd(5'd2, v);
        checks++;
        if (v !== 32'd5) begin errors++; $display("FAIL os_load: got %0d want 5", v); end
        cyc(1); rd(5'd2, v);
        checks++;
        if (v !== 32'd4) begin errors++; $display("FAIL os_dec: got %0d want 4", v); end
        cyc(4); rd(5'd3, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL os_early: got %0d want 0", v); end
        cyc(1); rd(5'd3, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL os_pending7: got %0d want 1", v); end
        checks++;
        if (irq !== 2'b00) begin errors++; $display("FAIL os_irq7: got %b want 00", irq); end
        cyc(1);
        checks++;
        if (irq !== 2'b01) begin errors++; $display("FAIL os_irq8: got %b want 01", irq); end
        rd(5'd0, v);
        checks++;
        if (v !== 32'h4) begin errors++; $display("FAIL os_en_clr: got %h want 4", v); end
        rd(5'd2, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL os_count0: got %0d want 0", v); end
        wr(5'd3, 32'h1);
        checks++;
        if (irq !== 2'b01) begin errors++; $display("FAIL os_irq_hold: got %b want 01", irq); end
        cyc(1);
        checks++;
        if (irq !== 2'b00) begin errors++; $display("FAIL os_irq_clr: got %b want 00", irq); end
        wr(5'd0, 32'h0);
    endtask

    task automatic test_autoreload;
        wr(5'd5, 32'd3);
        wr(5'd4, 32'h7);
        cyc(4); rd(5'd7, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL ar_p1_early: got %0d want 0", v); end
        cyc(1); rd(5'd7, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL ar_p1: got %0d want 1", v); end
        for (int p = 2; p <= 3; p++) begin
            wr(5'd7, 32'h1);
            rd(5'd7, v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL ar_clr%0d: got %0d want 0", p, v); end
            cyc(3); rd(5'd7, v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL ar_p%0d_early: got %0d want 0", p, v); end
            cyc(1); rd(5'd7, v);
            checks++;
            if (v !== 32'd1) begin errors++; $display("FAIL ar_p%0d: got %0d want 1", p, v); end
        end
        cyc(4);
        wr(5'd7, 32'h1);
        rd(5'd7, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL ar_set_wins: got %0d want 1", v); end
        checks++;
        if (irq !== 2'b10) begin errors++; $display("FAIL ar_irq: got %b want 10", irq); end
        wr(5'd4, 32'h0);
        wr(5'd7, 32'h1);
    endtask

    task automatic test_disable;
        wr(5'd1, 32'd100);
        wr(5'd0, 32'h5);
        cyc(41); rd(5'd2, v);
        checks++;
        if (v !== 32'd60) begin errors++; $display("FAIL dis_at60: got %0d want 60", v); end
        wr(5'd0, 32'h0);
        rd(5'd2, v);
        checks++;
        if (v !== 32'd59) begin errors++; $display("FAIL dis_freeze: got %0d want 59", v); end
        cyc(200); rd(5'd2, v);
        checks++;
        if (v !== 32'd59) begin errors++; $display("FAIL dis_hold: got %0d want 59", v); end
        rd(5'd3, v);
        checks++;
        if (v !== 32'd0 || irq !== 2'b00) begin errors++; $display("FAIL dis_noint: got pend=%0d irq=%b want 0/00", v, irq); end
        wr(5'd0, 32'h1);
        cyc(1); rd(5'd2, v);
        checks++;
        if (v !== 32'd100) begin errors++; $display("FAIL dis_reload: got %0d want 100", v); end
        wr(5'd1, 32'd10);
        cyc(1); rd(5'd2, v);
        checks++;
        if (v !== 32'd98) begin errors++; $display("FAIL dis_preset_cnt: got %0d want 98", v); end
        wr(5'd0, 32'h0);
    endtask

    task automatic test_mask;
        wr(5'd1, 32'd2);
        wr(5'd5, 32'd6);
        wr(5'd0, 32'h1);
        wr(5'd4, 32'h5);
        cyc(4); rd(5'd3, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL mask_pend: got %0d want 1", v); end
        checks++;
        if (irq !== 2'b00) begin errors++; $display("FAIL mask_irq: got %b want 00", irq); end
        rd(5'd6, v);
        checks++;
        if (v !== 32'd3) begin errors++; $display("FAIL mask_ch1cnt: got %0d want 3", v); end
        wr(5'd0, 32'h4);
        checks++;
        if (irq !== 2'b00) begin errors++; $display("FAIL mask_im_lag: got %b want 00", irq); end
        cyc(1);
        checks++;
        if (irq !== 2'b01) begin errors++; $display("FAIL mask_im_set: got %b want 01", irq); end
        cyc(3);
        checks++;
        if (irq !== 2'b11) begin errors++; $display("FAIL mask_ch1_irq: got %b want 11", irq); end
        wr(5'd0, 32'h0);
        wr(5'd4, 32'h0);
        wr(5'd3, 32'h1);
        wr(5'd7, 32'h1);
    endtask

    task automatic test_prescale;
        int          intv;
        logic [31:0] ctrl_exp;
`ifdef TIMER_BANK_PRESCALE_EN
        intv = 14; ctrl_exp = 32'h21;
`else
        intv = 6;  ctrl_exp = 32'h01;
`endif
        wr(5'd1, 32'd4);
        wr(5'd0, 32'h21);
        rd(5'd0, v);
        checks++;
        if (v !== ctrl_exp) begin errors++; $display("FAIL ps_ctrl: got %h want %h", v, ctrl_exp); end
        cyc(intv - 1); rd(5'd3, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL ps_early: got %0d want 0", v); end
        cyc(1); rd(5'd3, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL ps_interval: got %0d want 1", v); end
        wr(5'd3, 32'h1);
    endtask

    task automatic test_reset_midcount;
        wr(5'd5, 32'd3);
        wr(5'd4, 32'h7);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        rd(5'd4, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", v); end
        rd(5'd6, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rst_count: got %h want 0", v); end
        cyc(10); rd(5'd7, v);
        checks++;
        if (v !== 32'd0 || irq !== 2'b00) begin errors++; $display("FAIL rst_noint: got pend=%0d irq=%b want 0/00", v, irq); end
    endtask

    initial begin
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        #1;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_disable();
        test_mask();
        test_prescale();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised bank of programmable down-counting timers that sits behind the processor-side I/O bridge as a memory-mapped device and drives the hardware interrupt lines. It generalises the single fixed timer to NUM_CH independent channels, each with one-shot and auto-reload modes, a configurable counter width and a sticky, maskable interrupt. Register reads are combinational for the bridge read mux. Writes take effect on the next clock edge.

## Interface
- NUM_CH, default 2: number of timer channels, 1..6 (one per HWInt[7:2] line).
- WIDTH, default 32: counter/preset width, 1..32; unused upper bits read 0, writes truncated.
- ADDR_W, default 5: word-address width; must satisfy 2^ADDR_W >= 4*NUM_CH.
- clk  in  1  system clock. One clock; all state updates on its rising edge.
- rst  in  1  reset. Synchronous and active-high.
- addr  in  ADDR_W  word address within the device (bridge PrAddr bits already decoded).
- wdata  in  32  write data.
- we  in  1  write strobe for the selected device.
- rdata  out  32  read data, combinational from addr and register state.
- irq  out  NUM_CH  per-channel interrupt, registered: pending[i] & CTRL.IM[i].

## Operation
- Channel i occupies word offsets 4i..4i+3:
  - +0 CTRL, RW: [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [2] IM, [11:4] PS (see Configuration), other bits read 0.
  - +1 PRESET, RW.
  - +2 COUNT, RO; writes ignored.
  - +3 STATUS: [0] pending. Writing 1 to bit 0 clears pending; writing 0 has no effect.
- Addresses at channel >= NUM_CH or beyond read 0; writes to them are ignored.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: COUNT holds. EN=1 moves to LOAD.
  - LOAD: COUNT <= PRESET, then move to CNT.
  - CNT: on each tick, if COUNT > 1 then COUNT <= COUNT-1; otherwise COUNT <= 0 and move to INT. PRESET=0 behaves as PRESET=1.
  - INT: pending <= 1 for one cycle. In one-shot mode, EN <= 0 and move to IDLE. In auto-reload mode, move to LOAD.
- EN cleared by a write in any state: move to IDLE next edge; COUNT freezes at its current value.
- PRESET written during CNT: no effect until the next LOAD.
- Same-cycle STATUS clear and INT set: set wins, so pending stays 1.
- Same-cycle CTRL write and one-shot INT auto-clear of EN: the CPU write wins.
- MODE and IM changes apply from the next edge. IM does not affect pending, only irq.

## Timing
- Reset values: all CTRL, PRESET, COUNT and pending are 0; FSM in IDLE; irq = 0. rdata then reflects the zeroed registers.
- Without prescale, the interval from the EN write edge to pending = 1 is N+2 cycles (LOAD 1 + CNT N + INT 1), where N = max(PRESET,1).
- Auto-reload period: N+2 cycles.
- irq rises one cycle after pending is set.
- Reset asserted mid-count: all channels return to the reset state on that edge. No interrupt is generated.
- A read of COUNT returns the pre-edge value. A write followed by a read in the next cycle returns the new value.

## Configuration
- Macro: TIMER_BANK_PRESCALE_EN.
- Defined: CTRL[11:4] = PS is writable. The CNT state advances only on ticks from a per-channel prescale counter that fires every PS+1 cycles. The prescaler is cleared in LOAD, so the interval is N*(PS+1)+2 cycles. LOAD and INT are not prescaled.
- Undefined: CTRL[11:4] reads 0 and ignores writes. Every cycle is a tick.

## Structure
- Shared package timer_bank_pkg holds:
  - FSM state enum (IDLE, LOAD, CNT, INT).
  - Register offset constants (CTRL=0, PRESET=1, COUNT=2, STATUS=3).
  - CTRL bit positions, including the PS field.
  - MODE encodings.
- Sub-module timer_channel is instantiated NUM_CH times via generate. It holds one FSM, the channel registers, the optional prescaler and the pending flag.
- timer_bank holds address decode, the write-enable fan-out and the rdata mux.

## Test plan
- Reset values: hold rst 3 cycles → irq=0; CTRL, PRESET, COUNT and STATUS read 0 on all channels; reads of an unmapped address return 0.
- One-shot: ch0 PRESET=5, CTRL=0x5 (EN, IM) → pending at cycle 7 after the write edge, irq0=1 at cycle 8, EN reads 0, COUNT=0. Write STATUS=1 → irq0=0 next cycle.
- Auto-reload: ch1 PRESET=3, CTRL=0x7 → pending set every 5 cycles. After 4 periods, clear pending in the same cycle as an INT → pending remains 1.
- Disable mid-count: PRESET=100, enable, write CTRL=0 at COUNT=60 → COUNT freezes at 59±0 as defined by the write edge, and no interrupt follows for 200 cycles. Re-enable → reloads 100.
- Mask and independence: ch0 IM=0 expires → STATUS=1, irq0=0; ch1 counts concurrently, unaffected. Set IM → irq0=1 next cycle.
- Prescale (TIMER_BANK_PRESCALE_EN): PRESET=4, PS=2 → pending 14 cycles after enable. Without the macro, a PS write reads back 0 and the interval is 6.
